spi_cmd_handler: RTL
====================

// Module: spi_cmd_handler
// PURPOSE
//  Command/register stage directly downstream of SPI_COMM. Consumes each received byte (DATA_out + EoB),
//  decodes the frame header, executes register writes/reads and burst transfers, and feeds DATA_in/err_in
//  back to SPI_COMM for MISO. Holds the sniffer control register file; address 0 is a read-only STATUS byte.
// PARAMETERS
//  ADDR_W     5   register address width; register file depth = 2**ADDR_W bytes
//  MAX_BURST  16  max data bytes in one format=1 frame; data byte MAX_BURST+1 is an error
// PORTS
//  clk        in   1       system clock (same domain as SPI_COMM clk)
//  rst        in   1       asynchronous, active-low reset
//  EoB        in   1       1-clk pulse from SPI_COMM: byte complete, DATA_out valid
//  DATA_out   in   8       received byte from SPI_COMM
//  busy       in   1       high while SPI_COMM frame active; falling edge = frame end
//  err_out    in   1       SPI_COMM error flag
//  STATUS     in   8       value returned on reads of address 0
//  DATA_in    out  8       byte SPI_COMM shifts out on the next MISO byte
//  err_in     out  1       error flag to SPI_COMM
//  wr_stb     out  1       1-clk pulse per register write
//  wr_addr    out  ADDR_W  address of write
//  wr_data    out  8       data of write
//  frame_cnt  out  8       completed error-free frames, wraps 255->0
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, DATA_in=8'h00, err_in=0, wr_stb=0, wr_addr=0, wr_data=0, frame_cnt=0,
//   ptr_valid=0, register file all 8'h00.
//  Header = first EoB byte of a frame: CMD=hdr[7:3], sec=hdr[2], read=hdr[1], format=hdr[0].
//  Base address: if ptr_valid, base=ptr[ADDR_W-1:0] and ptr_valid clears at header; else base=CMD.
//  FSM: IDLE -(busy rises)-> HDR -(EoB)-> DATA -(busy falls)-> IDLE; any error -> ERR -(busy falls)-> IDLE.
//  HDR on EoB: latch fields, addr<=base, beats<=0. If read: DATA_in<=mem[base] (STATUS if 0) next clk.
//  DATA on EoB (each data byte):
//   - sec=1: byte stored to ptr, ptr_valid=1 (pointer frame; no reg write, read bit ignored).
//   - write: mem[addr]<=DATA_out, wr_stb pulse with wr_addr/wr_data, 1 clk after EoB. addr 0 -> ERR, no write.
//   - read: DATA_out ignored; DATA_in<=mem[addr+1] (read-ahead) 1 clk after EoB.
//   - format=0: only one data byte allowed; 2nd data byte -> ERR.
//   - format=1: addr increments mod 2**ADDR_W after each byte (wraps to 0; reads of 0 return STATUS,
//     writes to 0 error). beats==MAX_BURST on EoB -> ERR.
//  DATA_in is valid <=2 clk after EoB, well before next SCLK edge; held otherwise.
//  Frame end (busy 1->0): in DATA with >=1 data byte and no error -> frame_cnt+1. Ended in HDR or with
//   0 data bytes -> err_in=1 (incomplete), no writes. DATA_in<=8'h00 at frame end.
//  ERR: err_in=1, further EoBs ignored until busy falls. err_in stays set until next header EoB with
//   err_out=0. err_out=1 at any time -> ERR.
//  EoB and busy-fall in the same clk: EoB processed first, then frame end.
//  busy falling mid-byte (no EoB): partial byte discarded, handled as frame end above.
//  ptr_valid survives frame end; cleared only by reset or consumption by next header.
//  Reset mid-frame: immediate return to reset values; remainder of frame treated as new frame after busy.
// TESTING
//  T1 short write: hdr 8'hA8 (CMD=21), data 8'h69 -> wr_stb once, wr_addr=21, wr_data=8'h69, frame_cnt=1.
//  T2 pointer+burst: frame hdr 8'h04, data 8'h03; frame hdr 8'h01, data A1,69,66 -> writes 3,4,5 = A1,69,66;
//     ptr_valid=0 after.
//  T3 burst read: preload reg 3..5; hdr 8'h1B (CMD=3,read,format) + 3 dummies -> MISO bytes A1,69,66.
//  T4 errors: write to addr 0 -> err_in=1, no wr_stb; short frame with 2 data bytes -> err_in=1; frame_cnt unchanged.
//  T5 wrap/limit: ADDR_W=5 burst from 30, 3 bytes -> writes 30,31 then addr 0 error; 17-byte burst -> err on 17th.
//  T6 reset mid-burst: rst=0 after 2 data bytes -> all outputs to reset values; next frame decodes normally.

Source files
------------

// File: rtl/spi_cmd_handler.sv
// Command/register stage behind SPI_COMM: decodes frame headers, runs register
// writes, reads and bursts, and returns MISO data and error status to SPI_COMM.
module spi_cmd_handler #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EoB,
  input  logic [7:0]        DATA_out,
  input  logic              busy,
  input  logic              err_out,
  input  logic [7:0]        STATUS,
  output logic [7:0]        DATA_in,
  output logic              err_in,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned BW    = $clog2(MAX_BURST + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHdr  = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              busy_q;
  logic              sec_q, sec_d, rd_q, rd_d, fmt_q, fmt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     beats_q, beats_d;
  logic [7:0]        ptr_q, ptr_d;
  logic              ptr_valid_q, ptr_valid_d;
  logic [7:0]        data_in_q, data_in_d;
  logic              err_in_q, err_in_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [7:0]        mem_q [Depth];
  logic              we;

  logic              busy_rise, busy_fall, err_hit, go_err;
  logic [ADDR_W-1:0] base, addr_inc;
  logic [7:0]        hdr_rd, next_rd;

  assign busy_rise = busy & ~busy_q;
  assign busy_fall = ~busy & busy_q;
  assign err_hit   = err_out && (state_q != StIdle);
  assign base      = ptr_valid_q ? ptr_q[ADDR_W-1:0] : ADDR_W'(DATA_out[7:3]);
  assign addr_inc  = addr_q + ADDR_W'(1);
  // Address 0 is the read-only STATUS byte, never the register file.
  assign hdr_rd    = (base == '0) ? STATUS : mem_q[base];
  assign next_rd   = (addr_inc == '0) ? STATUS : mem_q[addr_inc];

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    rd_d        = rd_q;
    fmt_d       = fmt_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    ptr_d       = ptr_q;
    ptr_valid_d = ptr_valid_q;
    data_in_d   = data_in_q;
    err_in_d    = err_in_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_cnt_d = frame_cnt_q;
    we          = 1'b0;
    go_err      = err_hit;

    case (state_q)
      StIdle: begin
        if (busy_rise) state_d = StHdr;
      end
      StHdr: begin
        if (EoB && !err_hit) begin
          sec_d       = DATA_out[2];
          rd_d        = DATA_out[1];
          fmt_d       = DATA_out[0];
          addr_d      = base;
          beats_d     = '0;
          ptr_valid_d = 1'b0;
          err_in_d    = 1'b0;
          state_d     = StData;
          if (DATA_out[1]) data_in_d = hdr_rd;
        end
      end
      StData: begin
        if (EoB && !err_hit) begin
          if ((!fmt_q && beats_q != '0) || (beats_q == BW'(MAX_BURST))) begin
            go_err = 1'b1;
          end else if (sec_q) begin
            ptr_d       = DATA_out;
            ptr_valid_d = 1'b1;
            beats_d     = beats_q + BW'(1);
          end else if (rd_q) begin
            data_in_d = next_rd;
            beats_d   = beats_q + BW'(1);
            if (fmt_q) addr_d = addr_inc;
          end else if (addr_q == '0) begin
            go_err = 1'b1;
          end else begin
            we        = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = DATA_out;
            beats_d   = beats_q + BW'(1);
            if (fmt_q) addr_d = addr_inc;
          end
        end
      end
      default: ;
    endcase

    if (go_err) begin
      state_d  = StErr;
      err_in_d = 1'b1;
    end
    if (err_out && state_q == StIdle) err_in_d = 1'b1;

    // Frame end is evaluated after any same-cycle byte has been applied.
    if (busy_fall && state_q != StIdle) begin
      if (state_d == StData && beats_d != '0) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else if (state_d != StErr) begin
        err_in_d = 1'b1;
      end
      state_d   = StIdle;
      data_in_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      sec_q       <= 1'b0;
      rd_q        <= 1'b0;
      fmt_q       <= 1'b0;
      addr_q      <= '0;
      beats_q     <= '0;
      ptr_q       <= 8'h00;
      ptr_valid_q <= 1'b0;
      data_in_q   <= 8'h00;
      err_in_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      frame_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy;
      sec_q       <= sec_d;
      rd_q        <= rd_d;
      fmt_q       <= fmt_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      ptr_q       <= ptr_d;
      ptr_valid_q <= ptr_valid_d;
      data_in_q   <= data_in_d;
      err_in_q    <= err_in_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= 8'h00;
    end else if (we) begin
      mem_q[addr_q] <= DATA_out;
    end
  end

  assign DATA_in   = data_in_q;
  assign err_in    = err_in_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_cnt = frame_cnt_q;

endmodule
